// File: rtl/rvfi_fair_pkg.sv
// Shared types and constants for the RVFI bus fairness monitor.
//   fair_state_e : per-channel handshake state (IDLE / WAIT / RESP)
//   V_*          : bit positions of the per-channel violation vector
//   cnt_width()  : width of a stall counter that saturates at max_stall
package rvfi_fair_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fair_state_e;

  localparam int V_DROP   = 0;
  localparam int V_STABLE = 1;
  localparam int V_STALL  = 2;
  localparam int V_ERR    = 3;
  localparam int NVIOL    = 4;

  function automatic int cnt_width(input int max_stall);
    return (max_stall < 1) ? 1 : $clog2(max_stall + 1);
  endfunction

endpackage

// File: rtl/rvfi_bus_fairness_ch.sv
// One monitored request/grant channel: handshake FSM, saturating stall
// counter, payload capture register and sticky violation flags.
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_req .. i_gnt, i_err : channel handshake, payload and response error
//   o_must_gnt            : channel has stalled MAX_STALL cycles in WAIT
//   o_viol[NVIOL-1:0]     : sticky flags, indexed by V_DROP..V_ERR
module rvfi_bus_fairness_ch
  import rvfi_fair_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STALL  = 4,
  parameter int ALLOW_ERR  = 0,
  parameter int CHK_STABLE = 1,
  localparam int STRB_W    = DATA_W / 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_wen,
  input  logic [STRB_W-1:0] i_strb,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_gnt,
  input  logic              i_err,
  output logic              o_must_gnt,
  output logic [NVIOL-1:0]  o_viol
);

  localparam int             CW   = cnt_width(MAX_STALL);
  localparam logic [CW-1:0]  CMAX = CW'(MAX_STALL);

  fair_state_e       r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [STRB_W-1:0] r_strb;
  logic [DATA_W-1:0] r_wdata;
  logic [NVIOL-1:0]  r_viol, w_viol_set;
  logic              w_capture;
  logic              w_changed;

  // Write strobes and data only matter for a captured write.
  always_comb begin
    w_changed = (i_addr != r_addr) || (i_wen != r_wen) ||
                (r_wen && ((i_strb != r_strb) || (i_wdata != r_wdata)));
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_viol_set  = '0;
    case (r_state)
      WAIT: begin
        if (!i_req) begin
          w_state_nxt        = IDLE;
          w_cnt_nxt          = '0;
          w_viol_set[V_DROP] = 1'b1;
        end else begin
          if (i_gnt) begin
            w_state_nxt = RESP;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CMAX) begin
            w_viol_set[V_STALL] = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
          // Only reachable with req high, so a drop never also flags stability.
          if ((CHK_STABLE != 0) && w_changed)
            w_viol_set[V_STABLE] = 1'b1;
        end
      end
      default: begin
        // IDLE and RESP share next-state rules; RESP also samples err.
        if ((r_state == RESP) && (ALLOW_ERR == 0) && i_err)
          w_viol_set[V_ERR] = 1'b1;
        if (i_req && i_gnt) begin
          w_state_nxt = RESP;
          w_cnt_nxt   = '0;
        end else if (i_req) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = CW'(1);
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_strb  <= '0;
      r_wdata <= '0;
      r_viol  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_viol  <= r_viol | w_viol_set;
      if (w_capture) begin
        r_addr  <= i_addr;
        r_wen   <= i_wen;
        r_strb  <= i_strb;
        r_wdata <= i_wdata;
      end
    end
  end

  assign o_must_gnt = (r_state == WAIT) && (r_cnt == CMAX);
  assign o_viol     = r_viol;

endmodule

// File: rtl/rvfi_bus_fairness.sv
// Environment monitor for NCH request/grant memory channels (0 = imem,
// 1 = dmem). Each channel is checked independently; violations are sticky.
//   g_clk, g_reset      : clock, asynchronous active-high reset
//   req/addr/wen/strb/wdata/gnt/err : packed per-channel bus signals
//   must_gnt            : environment must grant a requesting channel now
//   viol_drop/stable/stall/err : sticky per-channel violation flags
//   fair                : no violation flag set on any channel
module rvfi_bus_fairness
  import rvfi_fair_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STALL  = 4,
  parameter int ALLOW_ERR  = 0,
  parameter int CHK_STABLE = 1,
  localparam int STRB_W    = DATA_W / 8
) (
  input  logic                  g_clk,
  input  logic                  g_reset,
  input  logic [NCH-1:0]        req,
  input  logic [NCH*ADDR_W-1:0] addr,
  input  logic [NCH-1:0]        wen,
  input  logic [NCH*STRB_W-1:0] strb,
  input  logic [NCH*DATA_W-1:0] wdata,
  input  logic [NCH-1:0]        gnt,
  input  logic [NCH-1:0]        err,
  output logic [NCH-1:0]        must_gnt,
  output logic [NCH-1:0]        viol_drop,
  output logic [NCH-1:0]        viol_stable,
  output logic [NCH-1:0]        viol_stall,
  output logic [NCH-1:0]        viol_err,
  output logic                  fair
);

  logic [NVIOL-1:0] w_viol [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    rvfi_bus_fairness_ch #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .MAX_STALL  (MAX_STALL),
      .ALLOW_ERR  (ALLOW_ERR),
      .CHK_STABLE (CHK_STABLE)
    ) u_ch (
      .i_clk      (g_clk),
      .i_rst      (g_reset),
      .i_req      (req[i]),
      .i_addr     (addr[i*ADDR_W +: ADDR_W]),
      .i_wen      (wen[i]),
      .i_strb     (strb[i*STRB_W +: STRB_W]),
      .i_wdata    (wdata[i*DATA_W +: DATA_W]),
      .i_gnt      (gnt[i]),
      .i_err      (err[i]),
      .o_must_gnt (must_gnt[i]),
      .o_viol     (w_viol[i])
    );

    assign viol_drop[i]   = w_viol[i][V_DROP];
    assign viol_stable[i] = w_viol[i][V_STABLE];
    assign viol_stall[i]  = w_viol[i][V_STALL];
    assign viol_err[i]    = w_viol[i][V_ERR];
  end

  assign fair = ~|{viol_drop, viol_stable, viol_stall, viol_err};

endmodule

// File: tb/tb_rvfi_bus_fairness.sv
module tb_rvfi_bus_fairness;

  localparam int NCH = 3;

  logic           g_clk = 1'b0;
  logic           g_reset;
  logic [NCH-1:0] req, wen, gnt, err;
  logic [NCH*32-1:0] addr, wdata;
  logic [NCH*4-1:0]  strb;

  logic [NCH-1:0] mg_a, drop_a, stab_a, stall_a, err_a;
  logic [NCH-1:0] mg_b, drop_b, stab_b, stall_b, err_b;
  logic           fair_a, fair_b;

  always #5 g_clk = ~g_clk;

  rvfi_bus_fairness #(.NCH(NCH), .ADDR_W(32), .DATA_W(32), .MAX_STALL(4),
                      .ALLOW_ERR(0), .CHK_STABLE(1)) dut_a (
    .g_clk(g_clk), .g_reset(g_reset), .req(req), .addr(addr), .wen(wen),
    .strb(strb), .wdata(wdata), .gnt(gnt), .err(err), .must_gnt(mg_a),
    .viol_drop(drop_a), .viol_stable(stab_a), .viol_stall(stall_a),
    .viol_err(err_a), .fair(fair_a));

  rvfi_bus_fairness #(.NCH(NCH), .ADDR_W(32), .DATA_W(32), .MAX_STALL(4),
                      .ALLOW_ERR(1), .CHK_STABLE(1)) dut_b (
    .g_clk(g_clk), .g_reset(g_reset), .req(req), .addr(addr), .wen(wen),
    .strb(strb), .wdata(wdata), .gnt(gnt), .err(err), .must_gnt(mg_b),
    .viol_drop(drop_b), .viol_stable(stab_b), .viol_stall(stall_b),
    .viol_err(err_b), .fair(fair_b));

  typedef struct {
    string       name;
    logic [15:0] va;
    logic [15:0] vb;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_assert = 0;
  int   n_fail   = 0;

  // Expected observation: {must_gnt, drop, stable, stall, err, fair}.
  function automatic logic [15:0] mk(input logic [2:0] mg, input logic [2:0] d,
                                     input logic [2:0] s, input logic [2:0] st,
                                     input logic [2:0] er);
    return {mg, d, s, st, er, ~|{d, s, st, er}};
  endfunction

  function automatic logic [15:0] obs_a();
    return {mg_a, drop_a, stab_a, stall_a, err_a, fair_a};
  endfunction

  function automatic logic [15:0] obs_b();
    return {mg_b, drop_b, stab_b, stall_b, err_b, fair_b};
  endfunction

  task automatic cyc();
    @(negedge g_clk);
  endtask

  task automatic clear_inputs();
    req = '0; wen = '0; gnt = '0; err = '0; addr = '0; wdata = '0; strb = '0;
  endtask

  task automatic set_ch(input int ch, input logic r, input logic g, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req[ch] = r; gnt[ch] = g; wen[ch] = w;
    addr[ch*32 +: 32] = a; wdata[ch*32 +: 32] = d; strb[ch*4 +: 4] = s;
  endtask

  task automatic do_reset();
    g_reset = 1'b1;
    clear_inputs();
    cyc(); cyc();
    g_reset = 1'b0;
  endtask

  task automatic test_reset();
    g_reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req = NCH'($urandom); gnt = NCH'($urandom); wen = NCH'($urandom);
      err = NCH'($urandom);
      addr = {$urandom, $urandom, $urandom}; wdata = {$urandom, $urandom, $urandom};
      strb = 12'($urandom);
      exp_q.push_back('{"reset_hold", mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0)});
      cyc();
      e = exp_q.pop_front(); n_assert++;
      if ({obs_a(), obs_b()} !== {e.va, e.vb}) begin
        n_fail++;
        $display("FAIL %s: got %h/%h expected %h/%h", e.name, obs_a(), obs_b(), e.va, e.vb);
      end
    end
    // Put ch0 into WAIT with cnt=2, then reset with req still high.
    clear_inputs();
    g_reset = 1'b0;
    set_ch(0, 1, 0, 0, 32'h40, 0, 0);
    cyc(); cyc();
    g_reset = 1'b1;
    cyc();
    g_reset = 1'b0;
    // Restarting from IDLE: must_gnt only after four more ungranted edges.
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back('{$sformatf("reset_midwait_%0d", k),
                        mk((k == 4) ? 3'b001 : 3'b000, 0, 0, 0, 0),
                        mk((k == 4) ? 3'b001 : 3'b000, 0, 0, 0, 0)});
      cyc();
      e = exp_q.pop_front(); n_assert++;
      if ({obs_a(), obs_b()} !== {e.va, e.vb}) begin
        n_fail++;
        $display("FAIL %s: got %h/%h expected %h/%h", e.name, obs_a(), obs_b(), e.va, e.vb);
      end
    end
  endtask

  task automatic test_stall(input bit grant_at_limit);
    do_reset();
    set_ch(0, 1, 0, 0, 32'h100, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back('{$sformatf("stall_cnt_%0d", k),
                        mk((k == 4) ? 3'b001 : 3'b000, 0, 0, 0, 0),
                        mk((k == 4) ? 3'b001 : 3'b000, 0, 0, 0, 0)});
      cyc();
      e = exp_q.pop_front(); n_assert++;
      if ({obs_a(), obs_b()} !== {e.va, e.vb}) begin
        n_fail++;
        $display("FAIL %s: got %h/%h expected %h/%h", e.name, obs_a(), obs_b(), e.va, e.vb);
      end
    end
    if (grant_at_limit) begin
      gnt[0] = 1'b1;
      exp_q.push_back('{"stall_granted", mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0)});
      cyc();
      req[0] = 1'b0; gnt[0] = 1'b0;
      exp_q.push_back('{"stall_granted_idle", mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0)});
      cyc();
    end else begin
      exp_q.push_back('{"stall_overflow", mk(3'b001, 0, 0, 3'b001, 0), mk(3'b001, 0, 0, 3'b001, 0)});
      cyc();
      exp_q.push_back('{"stall_sticky", mk(3'b001, 0, 0, 3'b001, 0), mk(3'b001, 0, 0, 3'b001, 0)});
      cyc();
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_assert++;
      if (e.name == "stall_granted" || e.name == "stall_overflow") begin
        // first of the two queued entries was due one cycle ago; recheck sticky state
      end
      if ({obs_a(), obs_b()} !== {e.va, e.vb}) begin
        n_fail++;
        $display("FAIL %s: got %h/%h expected %h/%h", e.name, obs_a(), obs_b(), e.va, e.vb);
      end
    end
  endtask

  task automatic test_drop();
    do_reset();
    set_ch(1, 1, 0, 0, 32'h2000, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) begin
        // Withdraw and change payload together: only the drop is reported.
        req[1] = 1'b0;
        addr[32 +: 32] = 32'h2004;
      end
      exp_q.push_back('{$sformatf("drop_step_%0d", k),
                        mk(0, (k == 3) ? 3'b010 : 3'b000, 0, 0, 0),
                        mk(0, (k == 3) ? 3'b010 : 3'b000, 0, 0, 0)});
      cyc();
      e = exp_q.pop_front(); n_assert++;
      if ({obs_a(), obs_b()} !== {e.va, e.vb}) begin
        n_fail++;
        $display("FAIL %s: got %h/%h expected %h/%h", e.name, obs_a(), obs_b(), e.va, e.vb);
      end
    end
  endtask

  // kind: 0 = read addr change, 1 = write wdata change, 2 = read wdata change,
  //       3 = addr change at the stall limit (both stall and stable)
  task automatic test_stable(input int kind);
    logic [2:0] s_exp, st_exp, mg_exp;
    do_reset();
    set_ch(0, 1, 0, (kind == 1), 32'h1000, 32'hCAFE_0000, 4'hF);
    for (int k = 0; k < ((kind == 3) ? 4 : 1); k++) cyc();
    case (kind)
      0, 3: addr[31:0] = 32'h1004;
      default: begin wdata[31:0] = 32'hCAFE_0001; strb[3:0] = 4'h3; end
    endcase
    s_exp  = (kind == 2) ? 3'b000 : 3'b001;
    st_exp = (kind == 3) ? 3'b001 : 3'b000;
    mg_exp = (kind == 3) ? 3'b001 : 3'b000;
    exp_q.push_back('{$sformatf("stable_kind_%0d", kind),
                      mk(mg_exp, 0, s_exp, st_exp, 0), mk(mg_exp, 0, s_exp, st_exp, 0)});
    cyc();
    e = exp_q.pop_front(); n_assert++;
    if ({obs_a(), obs_b()} !== {e.va, e.vb}) begin
      n_fail++;
      $display("FAIL %s: got %h/%h expected %h/%h", e.name, obs_a(), obs_b(), e.va, e.vb);
    end
  endtask

  task automatic test_err();
    do_reset();
    set_ch(1, 1, 1, 0, 32'h3000, 0, 0);
    cyc();
    req[1] = 1'b0; gnt[1] = 1'b0; err[1] = 1'b1;
    exp_q.push_back('{"err_resp", mk(0, 0, 0, 0, 3'b010), mk(0, 0, 0, 0, 0)});
    cyc();
    e = exp_q.pop_front(); n_assert++;
    if ({obs_a(), obs_b()} !== {e.va, e.vb}) begin
      n_fail++;
      $display("FAIL %s: got %h/%h expected %h/%h", e.name, obs_a(), obs_b(), e.va, e.vb);
    end
    do_reset();
    err = '1;
    for (int k = 1; k <= 2; k++) begin
      exp_q.push_back('{$sformatf("err_idle_%0d", k), mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0)});
      cyc();
      e = exp_q.pop_front(); n_assert++;
      if ({obs_a(), obs_b()} !== {e.va, e.vb}) begin
        n_fail++;
        $display("FAIL %s: got %h/%h expected %h/%h", e.name, obs_a(), obs_b(), e.va, e.vb);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] mg_exp, st_exp;
    do_reset();
    set_ch(2, 1, 0, 1, 32'h5000, 32'h1234_5678, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      set_ch(0, 1, 1, k[0], 32'h100 + 32'(4 * k), 32'(k), 4'(k));
      mg_exp = (k >= 4) ? 3'b100 : 3'b000;
      st_exp = (k >= 5) ? 3'b100 : 3'b000;
      exp_q.push_back('{$sformatf("b2b_%0d", k), mk(mg_exp, 0, 0, st_exp, 0),
                        mk(mg_exp, 0, 0, st_exp, 0)});
      cyc();
      e = exp_q.pop_front(); n_assert++;
      if ({obs_a(), obs_b()} !== {e.va, e.vb}) begin
        n_fail++;
        $display("FAIL %s: got %h/%h expected %h/%h", e.name, obs_a(), obs_b(), e.va, e.vb);
      end
    end
  endtask

  initial begin
    g_reset = 1'b1;
    clear_inputs();
    cyc();
    test_reset();
    test_stall(1'b1);
    test_stall(1'b0);
    test_drop();
    for (int k = 0; k < 4; k++) test_stable(k);
    test_err();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
